clock_mode_ctrl: RTL and testbench

//   Mode sequencer for the alarm-clock datapath. Sits between the front-panel switches/buttons and the

---
 rtl/clock_ctrl_pkg.sv | 28 ++
 rtl/btn_repeat.sv | 66 ++++++
 rtl/clock_mode_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared state encodings and sizing helper for the alarm-clock mode sequencer.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_T  = 3'd1,
        ST_SET_A  = 3'd2,
        ST_RING   = 3'd3,
        ST_SNOOZE = 3'd4
    } state_e;

    localparam logic [2:0] MODE_RUN    = 3'd0;
    localparam logic [2:0] MODE_SET_T  = 3'd1;
    localparam logic [2:0] MODE_SET_A  = 3'd2;
    localparam logic [2:0] MODE_RING   = 3'd3;
    localparam logic [2:0] MODE_SNOOZE = 3'd4;

    // Number of bits needed to hold values 0..maxVal (at least one bit).
    function automatic int cntWidth(input int maxVal);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((maxVal >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Front-panel button conditioner: 2-flop synchroniser, rising-edge detect and
// hold-to-repeat, producing a registered single-cycle strobe.
module btn_repeat
    import clock_ctrl_pkg::*;
#(
    parameter int REP_DELAY  = 24_000_000,
    parameter int REP_PERIOD = 6_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    input  logic en_i,
    output logic strobe_o
);

    localparam int CW = cntWidth((REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD);
    localparam logic [CW-1:0] DELAY_C  = CW'(REP_DELAY);
    localparam logic [CW-1:0] PERIOD_C = CW'(REP_PERIOD);

    logic          sync1_q, sync2_q, prev_q;
    logic          rep_q, rep_d;
    logic          strobe_q, strobe_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            rep_q    <= 1'b0;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            rep_q    <= rep_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    // cnt_q holds cycles since the last strobe; rep_q selects delay vs period.
    always_comb begin
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        strobe_d = 1'b0;
        if (!en_i || !sync2_q) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (!prev_q) begin
            strobe_d = 1'b1;
            cnt_d    = CW'(1);
            rep_d    = 1'b0;
        end else if ((!rep_q && cnt_q == DELAY_C) || (rep_q && cnt_q == PERIOD_C)) begin
            strobe_d = 1'b1;
            cnt_d    = CW'(1);
            rep_d    = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Alarm-clock mode sequencer: 1 s prescaler, set-time/set-alarm/ring/snooze FSM,
// button strobe routing and speaker gate.
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int REP_DELAY     = 24_000_000,
    parameter int REP_PERIOD    = 6_000_000,
    parameter int RING_SECS     = 60,
    parameter int SNOOZE_SECS   = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_time,
    input  logic       alarm,
    input  logic       Toggle_switch,
    input  logic       hours_set,
    input  logic       mins_set,
    input  logic       snooze,
    input  logic       alarm_match,
    output logic       sec_tick,
    output logic       time_hr_inc,
    output logic       time_min_inc,
    output logic       clr_sec,
    output logic       alm_hr_inc,
    output logic       alm_min_inc,
    output logic       disp_sel,
    output logic       Speaker_out_en,
    output logic [2:0] mode
);

    localparam int PW = cntWidth(TICKS_PER_SEC - 1);
    localparam int SW = cntWidth((RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS);
    localparam logic [PW-1:0] PRESC_MAX   = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] RING_LAST   = SW'(RING_SECS - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECS - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] prescCnt_q, prescCnt_d;
    logic          secTick_q, secTick_d;
    logic [SW-1:0] secCnt_q, secCnt_d;

    logic setTimeS1_q, setTime_q, alarmS1_q, alarm_q, toggleS1_q, toggle_q;
    logic snoozeS1_q, snooze_q, snoozePrev_q, matchPrev_q;
    logic snoozeRise, matchRise, inSet, hrStrobe, minStrobe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            setTimeS1_q  <= 1'b0;
            setTime_q    <= 1'b0;
            alarmS1_q    <= 1'b0;
            alarm_q      <= 1'b0;
            toggleS1_q   <= 1'b0;
            toggle_q     <= 1'b0;
            snoozeS1_q   <= 1'b0;
            snooze_q     <= 1'b0;
            snoozePrev_q <= 1'b0;
            matchPrev_q  <= 1'b0;
        end else begin
            setTimeS1_q  <= set_time;
            setTime_q    <= setTimeS1_q;
            alarmS1_q    <= alarm;
            alarm_q      <= alarmS1_q;
            toggleS1_q   <= Toggle_switch;
            toggle_q     <= toggleS1_q;
            snoozeS1_q   <= snooze;
            snooze_q     <= snoozeS1_q;
            snoozePrev_q <= snooze_q;
            matchPrev_q  <= alarm_match;
        end
    end

    assign snoozeRise = snooze_q & ~snoozePrev_q;
    assign matchRise  = alarm_match & ~matchPrev_q;
    assign inSet      = (state_q == ST_SET_T) || (state_q == ST_SET_A);

    btn_repeat #(.REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)) u_hrBtn (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (hours_set),
        .en_i     (inSet),
        .strobe_o (hrStrobe)
    );

    btn_repeat #(.REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)) u_minBtn (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (mins_set),
        .en_i     (inSet),
        .strobe_o (minStrobe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            prescCnt_q <= '0;
            secTick_q  <= 1'b0;
            secCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            prescCnt_q <= prescCnt_d;
            secTick_q  <= secTick_d;
            secCnt_q   <= secCnt_d;
        end
    end

    // Holding the prescaler at zero while setting time makes the first second afterwards full length.
    always_comb begin
        prescCnt_d = prescCnt_q + PW'(1);
        secTick_d  = 1'b0;
        if (state_q == ST_SET_T) begin
            prescCnt_d = '0;
        end else if (prescCnt_q == PRESC_MAX) begin
            prescCnt_d = '0;
            secTick_d  = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        secCnt_d = secTick_q ? secCnt_q + SW'(1) : secCnt_q;
        case (state_q)
            ST_RUN: begin
                if (setTime_q)                  state_d = ST_SET_T;
                else if (alarm_q)               state_d = ST_SET_A;
                else if (matchRise && toggle_q) state_d = ST_RING;
            end
            ST_SET_T: begin
                if (!setTime_q) state_d = ST_RUN;
            end
            ST_SET_A: begin
                if (setTime_q)     state_d = ST_SET_T;
                else if (!alarm_q) state_d = ST_RUN;
            end
            ST_RING: begin
                if (!toggle_q)                                state_d = ST_RUN;
                else if (snoozeRise)                          state_d = ST_SNOOZE;
                else if (secTick_q && secCnt_q == RING_LAST)  state_d = ST_RUN;
                else if (setTime_q)                           state_d = ST_SET_T;
                else if (alarm_q)                             state_d = ST_SET_A;
            end
            ST_SNOOZE: begin
                if (secTick_q && secCnt_q == SNOOZE_LAST) state_d = ST_RING;
                else if (!toggle_q)                       state_d = ST_RUN;
                else if (setTime_q)                       state_d = ST_SET_T;
                else if (alarm_q)                         state_d = ST_SET_A;
            end
            default: state_d = ST_RUN;
        endcase
        if (state_d != state_q || (state_q != ST_RING && state_q != ST_SNOOZE)) begin
            secCnt_d = '0;
        end
    end

    assign mode           = state_q;
    assign sec_tick       = secTick_q;
    assign disp_sel       = (state_q == ST_SET_A);
    assign Speaker_out_en = (state_q == ST_RING);
    assign time_hr_inc    = hrStrobe & (state_q == ST_SET_T);
    assign time_min_inc   = minStrobe & (state_q == ST_SET_T);
    assign clr_sec        = minStrobe & (state_q == ST_SET_T);
    assign alm_hr_inc     = hrStrobe & (state_q == ST_SET_A);
    assign alm_min_inc    = minStrobe & (state_q == ST_SET_A);

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed self-checking bench for clock_mode_ctrl using shortened timing parameters.
module tb_clock_mode_ctrl;

    localparam int TPS = 10;

    logic       clk = 1'b0;
    logic       reset, set_time, alarm, Toggle_switch, hours_set, mins_set, snooze, alarm_match;
    logic       sec_tick, time_hr_inc, time_min_inc, clr_sec, alm_hr_inc, alm_min_inc;
    logic       disp_sel, Speaker_out_en;
    logic [2:0] mode;

    int testsRun  = 0;
    int failCount = 0;
    int hrCnt, minCnt, clrCnt, clrMis, almHrCnt, almMinCnt, tickCnt, dispLow, ringCycles;
    int ticks;

    always #5 clk = ~clk;

    clock_mode_ctrl #(
        .TICKS_PER_SEC (10),
        .REP_DELAY     (20),
        .REP_PERIOD    (5),
        .RING_SECS     (3),
        .SNOOZE_SECS   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .set_time       (set_time),
        .alarm          (alarm),
        .Toggle_switch  (Toggle_switch),
        .hours_set      (hours_set),
        .mins_set       (mins_set),
        .snooze         (snooze),
        .alarm_match    (alarm_match),
        .sec_tick       (sec_tick),
        .time_hr_inc    (time_hr_inc),
        .time_min_inc   (time_min_inc),
        .clr_sec        (clr_sec),
        .alm_hr_inc     (alm_hr_inc),
        .alm_min_inc    (alm_min_inc),
        .disp_sel       (disp_sel),
        .Speaker_out_en (Speaker_out_en),
        .mode           (mode)
    );

    // Event counters sampled mid-cycle, cleared by the stimulus process just after a rising edge.
    always @(negedge clk) begin
        if (time_hr_inc)             hrCnt++;
        if (time_min_inc)            minCnt++;
        if (clr_sec)                 clrCnt++;
        if (clr_sec != time_min_inc) clrMis++;
        if (alm_hr_inc)              almHrCnt++;
        if (alm_min_inc)             almMinCnt++;
        if (sec_tick)                tickCnt++;
        if (!disp_sel)               dispLow++;
        if (mode == 3'd3)            ringCycles++;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clearCounts();
        hrCnt = 0; minCnt = 0; clrCnt = 0; clrMis = 0; almHrCnt = 0;
        almMinCnt = 0; tickCnt = 0; dispLow = 0; ringCycles = 0;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitMode(input string tag, input logic [2:0] m, input int bound);
        int k;
        k = 0;
        while (mode != m && k < bound) begin
            stepCycles(1);
            k++;
        end
        checkOutput(tag, int'(mode), int'(m));
    endtask

    task automatic cyclesToTick(input string tag, input int expected);
        int n;
        n = 0;
        do begin
            stepCycles(1);
            n++;
        end while (!sec_tick && n < 4 * TPS);
        if (!sec_tick) n = -1;
        checkOutput(tag, n, expected);
    endtask

    task automatic countModeTicks(input logic [2:0] m, input int bound, output int cnt);
        int k;
        k   = 0;
        cnt = 0;
        while (mode == m && k < bound) begin
            if (sec_tick) cnt++;
            stepCycles(1);
            k++;
        end
    endtask

    task automatic applyStimulus();
        // Reset state and first full second
        reset = 1'b1; set_time = 1'b0; alarm = 1'b0; Toggle_switch = 1'b0;
        hours_set = 1'b0; mins_set = 1'b0; snooze = 1'b0; alarm_match = 1'b0;
        clearCounts();
        stepCycles(3);
        checkOutput("rst_mode", int'(mode), 0);
        checkOutput("rst_speaker", int'(Speaker_out_en), 0);
        checkOutput("rst_tick", int'(sec_tick), 0);
        checkOutput("rst_disp", int'(disp_sel), 0);
        reset = 1'b0;
        cyclesToTick("first_tick", 10);

        // Time set: five hour pulses, one minute pulse, frozen seconds
        set_time = 1'b1;
        waitMode("enter_set_t", 3'd1, 6);
        stepCycles(1);
        clearCounts();
        repeat (5) begin
            hours_set = 1'b1; stepCycles(2);
            hours_set = 1'b0; stepCycles(2);
        end
        stepCycles(4);
        mins_set = 1'b1; stepCycles(2);
        mins_set = 1'b0; stepCycles(5);
        checkOutput("set_t_hr_inc", hrCnt, 5);
        checkOutput("set_t_min_inc", minCnt, 1);
        checkOutput("set_t_clr_sec", clrCnt, 1);
        checkOutput("set_t_clr_align", clrMis, 0);
        checkOutput("set_t_no_tick", tickCnt, 0);
        checkOutput("set_t_no_alm_inc", almHrCnt + almMinCnt, 0);
        set_time = 1'b0;
        waitMode("exit_set_t", 3'd0, 6);
        cyclesToTick("full_second", 10);

        // Alarm set with minute button held 40 cycles
        alarm = 1'b1;
        waitMode("enter_set_a", 3'd2, 6);
        checkOutput("set_a_disp", int'(disp_sel), 1);
        clearCounts();
        mins_set = 1'b1; stepCycles(40);
        mins_set = 1'b0; stepCycles(6);
        checkOutput("set_a_repeat", almMinCnt, 5);
        checkOutput("set_a_disp_held", dispLow, 0);
        checkOutput("set_a_no_time_inc", minCnt + hrCnt, 0);
        checkOutput("set_a_ticks_run", int'(tickCnt >= 4 && tickCnt <= 5), 1);
        alarm = 1'b0;
        waitMode("exit_set_a", 3'd0, 6);

        // Ring, self-cancel after three seconds, no re-ring with match held
        Toggle_switch = 1'b1;
        stepCycles(3);
        alarm_match = 1'b1;
        waitMode("ring_enter", 3'd3, 4);
        checkOutput("ring_speaker", int'(Speaker_out_en), 1);
        countModeTicks(3'd3, 60, ticks);
        checkOutput("ring_secs", ticks, 3);
        checkOutput("ring_timeout_mode", int'(mode), 0);
        clearCounts();
        hours_set = 1'b1; stepCycles(2);
        hours_set = 1'b0; stepCycles(28);
        checkOutput("no_rering", ringCycles, 0);
        checkOutput("run_btn_ignored", hrCnt + almHrCnt, 0);

        // Snooze then re-ring, toggle off cancels
        alarm_match = 1'b0; stepCycles(2);
        alarm_match = 1'b1;
        waitMode("ring2_enter", 3'd3, 4);
        snooze = 1'b1; stepCycles(3);
        snooze = 1'b0;
        waitMode("snooze_enter", 3'd4, 3);
        checkOutput("snooze_speaker", int'(Speaker_out_en), 0);
        countModeTicks(3'd4, 40, ticks);
        checkOutput("snooze_secs", ticks, 2);
        checkOutput("snooze_rering", int'(mode), 3);
        checkOutput("rering_speaker", int'(Speaker_out_en), 1);
        Toggle_switch = 1'b0;
        stepCycles(3);
        checkOutput("toggle_off_run", int'(mode), 0);

        // set_time beats alarm from RUN
        set_time = 1'b1; alarm = 1'b1;
        waitMode("both_set", 3'd1, 6);
        checkOutput("both_set_disp", int'(disp_sel), 0);
        set_time = 1'b0; alarm = 1'b0;
        waitMode("both_exit", 3'd0, 6);

        // alarm switch during RING silences into SET_A
        Toggle_switch = 1'b1; alarm_match = 1'b0;
        stepCycles(3);
        alarm_match = 1'b1;
        waitMode("ring3_enter", 3'd3, 4);
        alarm = 1'b1;
        waitMode("ring_to_set_a", 3'd2, 5);
        checkOutput("ring_to_set_a_spk", int'(Speaker_out_en), 0);
        checkOutput("ring_to_set_a_disp", int'(disp_sel), 1);
        alarm = 1'b0;
        waitMode("set_a_to_run", 3'd0, 6);

        // Asynchronous reset while ringing
        alarm_match = 1'b0; stepCycles(2);
        alarm_match = 1'b1;
        waitMode("ring4_enter", 3'd3, 4);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_mode", int'(mode), 0);
        checkOutput("async_rst_speaker", int'(Speaker_out_en), 0);
        checkOutput("async_rst_strobes",
                    int'({sec_tick, time_hr_inc, time_min_inc, clr_sec, alm_hr_inc, alm_min_inc}), 0);
        alarm_match = 1'b0;
        stepCycles(1);
        reset = 1'b0;
        cyclesToTick("post_reset_tick", 10);
    endtask

    initial begin
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
